// File: rtl/cyclic_encoder7_4_if.sv
// Handshake and output bundle for the serial (7,4) cyclic encoder.
//   master : drives the message (in_valid, in_data) and observes the encoder outputs
//   slave  : the encoder itself
// Signals:
//   in_valid   message present
//   in_data    message m[3:0], m[3] highest order
//   in_ready   encoder idle and able to accept
//   ser_out    serial codeword bit, c[6] first
//   ser_valid  ser_out carries a codeword bit
//   code_out   last completed codeword {m[3:0], parity[2:0]}
//   code_valid one-cycle pulse when code_out updates
// Optional feature macro ERR_INJECT_EN adds err_en / err_pos (bit-flip injection).
interface cyclic_encoder7_4_if;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       ser_out;
   logic       ser_valid;
   logic [6:0] code_out;
   logic       code_valid;
`ifdef ERR_INJECT_EN
   logic       err_en;
   logic [2:0] err_pos;

   modport master (
      output in_valid, in_data, err_en, err_pos,
      input  in_ready, ser_out, ser_valid, code_out, code_valid
   );
   modport slave (
      input  in_valid, in_data, err_en, err_pos,
      output in_ready, ser_out, ser_valid, code_out, code_valid
   );
`else
   modport master (
      output in_valid, in_data,
      input  in_ready, ser_out, ser_valid, code_out, code_valid
   );
   modport slave (
      input  in_valid, in_data,
      output in_ready, ser_out, ser_valid, code_out, code_valid
   );
`endif
endinterface

// File: rtl/cyclic_encoder7_4.sv
// Serial systematic (7,4) cyclic-code encoder, g(x) = x^3 + POLY[2]x^2 + POLY[1]x + POLY[0].
// Accepts one 4-bit message per handshake, streams the 7-bit codeword MSB first
// (message bits then parity) and then presents it in parallel with a one-cycle pulse.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  cyclic_encoder7_4_if.slave (handshake, serial and parallel outputs)
// Optional feature: define ERR_INJECT_EN to add err_en/err_pos on the interface; the
// selected codeword bit is inverted after encoding in both the stream and code_out.
// POLY[0] must be 1 for g(x) to be a valid generator.
module cyclic_encoder7_4 #(
   parameter logic [2:0] POLY = 3'b011
) (
   input  logic               clk,
   input  logic               rst,
   cyclic_encoder7_4_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StMsg, StPar} state_t;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_cnt, w_cnt_nxt;        // codeword bits already emitted
   logic [2:0] r_lfsr, w_lfsr_nxt;      // {r2, r1, r0}
   logic [3:0] r_msg, w_msg_nxt;        // remaining message bits, next one at [3]
   logic [6:0] r_acc, w_acc_nxt;        // clean codeword bits emitted so far
   logic [6:0] r_mask, w_mask_nxt;      // bit-flip mask latched at accept
   logic       r_ser_out, w_ser_out_nxt;
   logic       r_ser_valid, w_ser_valid_nxt;
   logic [6:0] r_code_out, w_code_out_nxt;
   logic       r_code_valid, w_code_valid_nxt;

   logic       w_bit;
   logic       w_fb;
   logic       w_emit;
   logic [2:0] w_idx;
   logic [6:0] w_err_mask;

`ifdef ERR_INJECT_EN
   assign w_err_mask = (bus.err_en && (bus.err_pos != 3'd7)) ? (7'd1 << bus.err_pos) : 7'd0;
`else
   assign w_err_mask = 7'd0;
`endif

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_lfsr_nxt       = r_lfsr;
      w_msg_nxt        = r_msg;
      w_acc_nxt        = r_acc;
      w_mask_nxt       = r_mask;
      w_ser_out_nxt    = r_ser_out;
      w_ser_valid_nxt  = r_ser_valid;
      w_code_out_nxt   = r_code_out;
      w_code_valid_nxt = 1'b0;
      w_bit            = 1'b0;
      w_fb             = 1'b0;
      w_emit           = 1'b0;
      w_idx            = 3'd6 - r_cnt;

      unique case (r_state)
         StIdle: begin
            if (bus.in_valid) begin
               // LFSR is always zero here, so the first step needs no special case
               w_bit           = bus.in_data[3];
               w_fb            = w_bit ^ r_lfsr[2];
               w_lfsr_nxt      = {r_lfsr[1] ^ (w_fb & POLY[2]), r_lfsr[0] ^ (w_fb & POLY[1]), w_fb};
               w_msg_nxt       = {bus.in_data[2:0], 1'b0};
               w_mask_nxt      = w_err_mask;
               w_acc_nxt       = {6'b0, w_bit};
               w_ser_out_nxt   = w_bit ^ w_err_mask[6];
               w_ser_valid_nxt = 1'b1;
               w_cnt_nxt       = 3'd1;
               w_state_nxt     = StMsg;
            end
         end
         StMsg: begin
            w_emit = 1'b1;
            if (r_cnt != 3'd4) begin
               w_bit      = r_msg[3];
               w_fb       = w_bit ^ r_lfsr[2];
               w_lfsr_nxt = {r_lfsr[1] ^ (w_fb & POLY[2]), r_lfsr[0] ^ (w_fb & POLY[1]), w_fb};
               w_msg_nxt  = {r_msg[2:0], 1'b0};
            end else begin
               // all message bits absorbed: LFSR now holds {c2, c1, c0}
               w_bit       = r_lfsr[2];
               w_lfsr_nxt  = {r_lfsr[1:0], 1'b0};
               w_state_nxt = StPar;
            end
         end
         StPar: begin
            if (r_cnt != 3'd7) begin
               w_emit     = 1'b1;
               w_bit      = r_lfsr[2];
               w_lfsr_nxt = {r_lfsr[1:0], 1'b0};
            end else begin
               w_state_nxt      = StIdle;
               w_cnt_nxt        = 3'd0;
               w_ser_out_nxt    = 1'b0;
               w_ser_valid_nxt  = 1'b0;
               w_code_out_nxt   = r_acc ^ r_mask;
               w_code_valid_nxt = 1'b1;
               w_acc_nxt        = 7'd0;
               w_mask_nxt       = 7'd0;
            end
         end
         default: w_state_nxt = StIdle;
      endcase

      if (w_emit) begin
         w_ser_out_nxt = w_bit ^ r_mask[w_idx];
         w_acc_nxt     = {r_acc[5:0], w_bit};
         w_cnt_nxt     = r_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_cnt        <= 3'd0;
         r_lfsr       <= 3'd0;
         r_msg        <= 4'd0;
         r_acc        <= 7'd0;
         r_mask       <= 7'd0;
         r_ser_out    <= 1'b0;
         r_ser_valid  <= 1'b0;
         r_code_out   <= 7'd0;
         r_code_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_lfsr       <= w_lfsr_nxt;
         r_msg        <= w_msg_nxt;
         r_acc        <= w_acc_nxt;
         r_mask       <= w_mask_nxt;
         r_ser_out    <= w_ser_out_nxt;
         r_ser_valid  <= w_ser_valid_nxt;
         r_code_out   <= w_code_out_nxt;
         r_code_valid <= w_code_valid_nxt;
      end
   end

   assign bus.in_ready   = (r_state == StIdle);
   assign bus.ser_out    = r_ser_out;
   assign bus.ser_valid  = r_ser_valid;
   assign bus.code_out   = r_code_out;
   assign bus.code_valid = r_code_valid;

endmodule
